// File: rtl/wb_b3_burst_master.sv
// Wishbone B3 initiator: turns one command into a classic single cycle or an
// incrementing burst (linear or 4/8/16-beat wrap), streaming write/read data.
module wb_b3_burst_master #(
    parameter int dw    = 32,
    parameter int aw    = 32,
    parameter int len_w = 4
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n_i,
    // command channel
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [aw-1:0]     cmd_adr_i,
    input  logic              cmd_we_i,
    input  logic [len_w-1:0]  cmd_len_i,
    input  logic [1:0]        cmd_bte_i,
    // write data stream
    input  logic [dw-1:0]     wdat_i,
    input  logic              wdat_valid_i,
    output logic              wdat_ready_o,
    // read data stream and completion
    output logic [dw-1:0]     rdat_o,
    output logic              rdat_valid_o,
    output logic              done_o,
    output logic              err_o,
    // Wishbone master side
    output logic [aw-1:0]     wb_adr_o,
    output logic [dw-1:0]     wb_dat_o,
    output logic [dw/8-1:0]   wb_sel_o,
    output logic              wb_we_o,
    output logic [1:0]        wb_bte_o,
    output logic [2:0]        wb_cti_o,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    input  logic [dw-1:0]     wb_dat_i,
    input  logic              wb_ack_i,
    input  logic              wb_err_i,
    input  logic              wb_rty_i
);

    localparam int bpw = dw / 8;

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t            state_q, state_d;
    logic [aw-1:0]     adr_q;
    logic              we_q;
    logic [1:0]        bte_q;
    logic [len_w-1:0]  cnt_q;
    logic              classic_q;
    logic [dw-1:0]     rdat_q;
    logic              rdat_valid_q;
    logic              done_q;
    logic              err_q;

    logic              cmd_accept;
    logic              stb;
    logic              abort;
    logic              beat_ack;
    logic              last_ack;
    logic [aw-1:0]     adr_inc;
    logic [aw-1:0]     wrap_mask;
    logic [aw-1:0]     adr_nxt;

    assign cmd_accept = cmd_valid_i & (state_q == IDLE);
    assign stb        = (state_q == BURST) & (~we_q | wdat_valid_i);
    // err/rty outrank a simultaneous ack; acks without stb are ignored
    assign abort      = stb & (wb_err_i | wb_rty_i);
    assign beat_ack   = stb & wb_ack_i & ~abort;
    assign last_ack   = beat_ack & (cnt_q == '0);

    // Wrap bursts only advance the low word-index bits inside the wrap window
    always_comb begin
        adr_inc   = adr_q + aw'(bpw);
        wrap_mask = '0;
        case (bte_q)
            2'b01:   wrap_mask = aw'(4 * bpw - 1);
            2'b10:   wrap_mask = aw'(8 * bpw - 1);
            2'b11:   wrap_mask = aw'(16 * bpw - 1);
            default: wrap_mask = '0;
        endcase
        if (bte_q == 2'b00) begin
            adr_nxt = adr_inc;
        end else begin
            adr_nxt = (adr_q & ~wrap_mask) | (adr_inc & wrap_mask);
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cmd_ready_o = 1'b0;
        wb_cyc_o    = 1'b0;
        wb_stb_o    = 1'b0;
        wb_we_o     = 1'b0;
        wb_sel_o    = '0;
        wb_cti_o    = 3'b000;
        wb_bte_o    = 2'b00;
        case (state_q)
            IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    state_d = BURST;
                end
            end
            BURST: begin
                wb_cyc_o = 1'b1;
                wb_stb_o = stb;
                wb_we_o  = we_q;
                wb_sel_o = '1;
                if (!classic_q) begin
                    wb_bte_o = bte_q;
                    wb_cti_o = (cnt_q == '0) ? 3'b111 : 3'b010;
                end
                if (last_ack || abort) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            adr_q     <= '0;
            we_q      <= 1'b0;
            bte_q     <= 2'b00;
            cnt_q     <= '0;
            classic_q <= 1'b0;
        end else if (cmd_accept) begin
            adr_q     <= cmd_adr_i;
            we_q      <= cmd_we_i;
            bte_q     <= cmd_bte_i;
            cnt_q     <= cmd_len_i;
            classic_q <= (cmd_len_i == '0);
        end else if (beat_ack) begin
            adr_q     <= adr_nxt;
            cnt_q     <= cnt_q - 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            rdat_q       <= '0;
            rdat_valid_q <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            rdat_valid_q <= beat_ack & ~we_q;
            if (beat_ack && !we_q) begin
                rdat_q <= wb_dat_i;
            end
            done_q <= last_ack | abort;
            err_q  <= abort;
        end
    end

    assign wb_adr_o     = adr_q;
    assign wb_dat_o     = wdat_i;
    assign wdat_ready_o = beat_ack & we_q;
    assign rdat_o       = rdat_q;
    assign rdat_valid_o = rdat_valid_q;
    assign done_o       = done_q;
    assign err_o        = err_q;

endmodule
